// File: rtl/bcd_stopwatch_mux.sv
// N-digit BCD stopwatch with prescaled stepping, preset load, pause/lap hold,
// optional wrap-around and a multiplexed common-anode 7-segment driver.

module bcd_digit (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);
    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= 4'd9) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = 4'd9;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_stopwatch_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 500,
    parameter int WRAP       = 0
) (
    input  logic                    fiveHundredHzClk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] preset_bcd,
    input  logic                    count_up,
    input  logic                    lap_hold,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic [1:0]              state_o,
    output logic                    count_done,
    output logic [2:0]              mode_led
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;

    state_t                         state, state_n;
    logic [NUM_DIGITS-1:0][3:0]     cnt, cnt_n, cnt_step, preset_clamp, term, latch, disp;
    logic [NUM_DIGITS:0]            carry;
    logic [PW-1:0]                  presc, presc_n;
    logic [IW-1:0]                  idx, idx_n;
    logic                           step, at_term, pulse_n, pulse_q, lap_q;

    function automatic logic [6:0] seg_dec(input logic [3:0] n);
        case (n)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h7F;
        endcase
    endfunction

    // Ripple carry/borrow chain; the top carry-out marks a terminal->wrap step.
    assign carry[0] = 1'b1;
    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
            bcd_digit u_dig (
                .d    (cnt[i]),
                .up   (count_up),
                .cin  (carry[i]),
                .q    (cnt_step[i]),
                .cout (carry[i+1])
            );
            assign preset_clamp[i] = (preset_bcd[4*i +: 4] > 4'd9) ? 4'd9 : preset_bcd[4*i +: 4];
            assign term[i]         = count_up ? 4'd9 : 4'd0;
        end
    endgenerate

    assign at_term = (cnt == term);
    assign step    = (state == RUN) && (presc == PW'(TICK_DIV - 1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        presc_n = presc;
        pulse_n = 1'b0;
        if (clear) begin
            cnt_n   = '0;
            presc_n = '0;
            state_n = IDLE;
        end else if (load) begin
            cnt_n   = preset_clamp;
            presc_n = '0;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    presc_n = '0;
                    if (start && !stop) state_n = RUN;
                end
                RUN: begin
                    presc_n = step ? '0 : presc + PW'(1);
                    if (step) begin
                        if (at_term && WRAP == 0) begin
                            state_n = DONE;
                        end else begin
                            cnt_n   = cnt_step;
                            pulse_n = (WRAP != 0) && carry[NUM_DIGITS];
                            if (WRAP == 0 && cnt_step == term) state_n = DONE;
                        end
                    end
                    // A coincident step still lands before the pause.
                    if (stop) state_n = PAUSED;
                end
                PAUSED: begin
                    if (start && !stop) state_n = RUN;
                end
                DONE: begin
                    presc_n = '0;
                    if (start && !stop && !at_term) state_n = RUN;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign disp  = lap_q ? latch : cnt;
    assign idx_n = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);

    always_ff @(posedge fiveHundredHzClk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            presc   <= '0;
            pulse_q <= 1'b0;
            lap_q   <= 1'b0;
            latch   <= '0;
            idx     <= '0;
            seg     <= 7'h7F;
            an      <= '1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            presc   <= presc_n;
            pulse_q <= pulse_n;
            lap_q   <= lap_hold;
            if (lap_hold && !lap_q) latch <= cnt_n;
            idx     <= idx_n;
            an      <= ~(NUM_DIGITS'(1) << idx);
            seg     <= seg_dec(disp[idx]);
        end
    end

    assign count_bcd  = cnt;
    assign state_o    = state;
    assign count_done = (WRAP != 0) ? pulse_q : (state == DONE);
    assign mode_led   = {state != RUN, (state == RUN) & ~count_up, (state == RUN) & count_up};
endmodule
